// File: rtl/uart_cmd_arbiter.sv
// Round-robin arbiter that shares one UART command port among NUM_REQ requesters,
// tracks the single outstanding command and returns read data or a timeout error.
module uart_cmd_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned CMD_WIDTH   = 16,
    parameter int unsigned READ_WIDTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_vld,
    input  logic [NUM_REQ*CMD_WIDTH-1:0]   req_cmd,
    output logic [NUM_REQ-1:0]             req_rdy,
    output logic [NUM_REQ-1:0]             rsp_vld,
    output logic [READ_WIDTH-1:0]          rsp_data,
    output logic                           rsp_err,
    output logic [CMD_WIDTH-1:0]           uart_cmd,
    output logic                           uart_cmd_vld,
    input  logic                           uart_cmd_rdy,
    input  logic                           uart_read_rdy,
    input  logic [READ_WIDTH-1:0]          uart_read_data,
    output logic                           busy
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        WAIT_RSP  = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    state_t                  state_q, state_n;
    logic [PTR_W-1:0]        ptr_q, ptr_n;
    logic [PTR_W-1:0]        owner_q, owner_n;
    logic                    wd_first_q, wd_first_n;
    logic [CNT_W-1:0]        cnt_q, cnt_n;

    logic [NUM_REQ-1:0]      req_rdy_n;
    logic [NUM_REQ-1:0]      rsp_vld_n;
    logic [READ_WIDTH-1:0]   rsp_data_n;
    logic                    rsp_err_n;
    logic [CMD_WIDTH-1:0]    uart_cmd_n;
    logic                    uart_cmd_vld_n;
    logic                    busy_n;

    logic                    gnt_found;
    logic [PTR_W-1:0]        gnt_idx;
    logic [PTR_W-1:0]        cand;
    logic                    is_read;

    // The latched command's top bit marks a read
    assign is_read = uart_cmd[CMD_WIDTH-1];

    // Round-robin search starting one past the last granted requester
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((32'(ptr_q) + 32'd1 + i) % NUM_REQ);
            if (!gnt_found && req_vld[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= PTR_W'(NUM_REQ - 1);
            owner_q      <= '0;
            wd_first_q   <= 1'b0;
            cnt_q        <= '0;
            req_rdy      <= '0;
            rsp_vld      <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            uart_cmd     <= '0;
            uart_cmd_vld <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_n;
            ptr_q        <= ptr_n;
            owner_q      <= owner_n;
            wd_first_q   <= wd_first_n;
            cnt_q        <= cnt_n;
            req_rdy      <= req_rdy_n;
            rsp_vld      <= rsp_vld_n;
            rsp_data     <= rsp_data_n;
            rsp_err      <= rsp_err_n;
            uart_cmd     <= uart_cmd_n;
            uart_cmd_vld <= uart_cmd_vld_n;
            busy         <= busy_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n        = state_q;
        ptr_n          = ptr_q;
        owner_n        = owner_q;
        wd_first_n     = 1'b0;
        cnt_n          = cnt_q;
        req_rdy_n      = '0;
        rsp_vld_n      = '0;
        rsp_data_n     = rsp_data;
        rsp_err_n      = rsp_err;
        uart_cmd_n     = uart_cmd;

        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    state_n            = ISSUE;
                    req_rdy_n[gnt_idx] = 1'b1;
                    ptr_n              = gnt_idx;
                    owner_n            = gnt_idx;
                    uart_cmd_n         = req_cmd[32'(gnt_idx) * CMD_WIDTH +: CMD_WIDTH];
                end
            end
            ISSUE: begin
                if (uart_cmd_vld && uart_cmd_rdy) begin
                    state_n    = WAIT_DONE;
                    wd_first_n = 1'b1;
                end
            end
            WAIT_DONE: begin
                // Read data that beats the end-of-frame indication is taken directly
                if (is_read && uart_read_rdy) begin
                    state_n            = RESPOND;
                    rsp_vld_n[owner_q] = 1'b1;
                    rsp_data_n         = uart_read_data;
                    rsp_err_n          = 1'b0;
                end else if (!wd_first_q && uart_cmd_rdy) begin
                    if (is_read) begin
                        state_n = WAIT_RSP;
                        cnt_n   = '0;
                    end else begin
                        state_n            = RESPOND;
                        rsp_vld_n[owner_q] = 1'b1;
                        rsp_data_n         = '0;
                        rsp_err_n          = 1'b0;
                    end
                end
            end
            WAIT_RSP: begin
                if (uart_read_rdy) begin
                    state_n            = RESPOND;
                    rsp_vld_n[owner_q] = 1'b1;
                    rsp_data_n         = uart_read_data;
                    rsp_err_n          = 1'b0;
                end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT_CYC)) begin
                    state_n            = RESPOND;
                    rsp_vld_n[owner_q] = 1'b1;
                    rsp_data_n         = '1;
                    rsp_err_n          = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            RESPOND: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        uart_cmd_vld_n = (state_n == ISSUE);
        busy_n         = (state_n != IDLE);
    end

endmodule

// File: doc/uart_cmd_arbiter.md
UART_CMD_ARBITER -- requirements
Module: uart_cmd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one UART command port (2..8).
REQ-002 Parameter CMD_WIDTH, default 16, command width; bit CMD_WIDTH-1 = rw flag (1 = read, 0 = write).
REQ-003 Parameter READ_WIDTH, default 8, read response data width.
REQ-004 Parameter TIMEOUT_CYC, default 65535, max clk cycles to wait for a read response.
REQ-005 The block SHALL use clock clk and reset rst_n, asynchronous, active-low.
REQ-006 clk  input  1  system clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 req_vld  input  NUM_REQ  per-requester command valid.
REQ-009 req_cmd  input  NUM_REQ*CMD_WIDTH  packed commands; requester i occupies bits [i*CMD_WIDTH +: CMD_WIDTH].
REQ-010 req_rdy  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-011 rsp_vld  output  NUM_REQ  one-cycle response pulse to the owning requester.
REQ-012 rsp_data  output  READ_WIDTH  response data, valid with rsp_vld.
REQ-013 rsp_err  output  1  timeout flag, valid with rsp_vld.
REQ-014 uart_cmd  output  CMD_WIDTH  command to UART.
REQ-015 uart_cmd_vld  output  1  command valid to UART.
REQ-016 uart_cmd_rdy  input  1  UART idle/ready; UART drops it the cycle after acceptance and raises it when the frame completes.
REQ-017 uart_read_rdy  input  1  UART read-data-valid pulse.
REQ-018 uart_read_data  input  READ_WIDTH  UART received byte.
REQ-019 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT_DONE, WAIT_RSP, RESPOND.
REQ-021 IDLE: if any req_vld, grant round-robin starting at index ptr+1 mod NUM_REQ; pulse req_rdy[grant] for one cycle, latch req_cmd[grant] and owner index, go to ISSUE.
REQ-022 After a grant, ptr SHALL be set to the granted index; ptr resets to NUM_REQ-1, so requester 0 has first priority.
REQ-023 ISSUE: uart_cmd_vld=1, uart_cmd=latched command held stable; on uart_cmd_vld && uart_cmd_rdy go to WAIT_DONE next cycle.
REQ-024 WAIT_DONE: uart_cmd_vld=0; the first cycle is ignored; thereafter uart_cmd_rdy=1 ends the frame: write -> RESPOND (rsp_data=0, rsp_err=0); read -> WAIT_RSP.
REQ-025 WAIT_RSP: timeout counter increments each cycle; uart_read_rdy captures uart_read_data -> RESPOND, rsp_err=0; counter reaching TIMEOUT_CYC -> RESPOND, rsp_data all ones, rsp_err=1.
REQ-026 uart_read_rdy arriving in WAIT_DONE SHALL be captured and skip WAIT_RSP; in IDLE/ISSUE it SHALL be ignored.
REQ-027 RESPOND: rsp_vld[owner]=1 for exactly one cycle, then IDLE; no grant issued in RESPOND cycle.
REQ-028 Minimum spacing between consecutive grants SHALL be 4 cycles; at most one command outstanding.
REQ-029 req_cmd of non-granted requesters SHALL be ignored; requesters hold req_vld/req_cmd until req_rdy.
REQ-030 req_vld deasserted before grant SHALL NOT produce a grant or response.
REQ-031 Timeout counter width SHALL be clog2(TIMEOUT_CYC+1); counter cleared on entering WAIT_RSP.

Reset
REQ-032 During reset: state IDLE, all outputs 0 (req_rdy, rsp_vld, rsp_data, rsp_err, uart_cmd, uart_cmd_vld, busy), ptr=NUM_REQ-1, counter 0.
REQ-033 Reset mid-transaction SHALL abort it with no rsp_vld; after release the arbiter behaves as from power-up.

Verification
REQ-034 Single write: req_vld[2]=1, cmd=16'h1234 -> req_rdy[2] pulse, uart_cmd=16'h1234 with uart_cmd_vld until accept, rsp_vld[2] pulse with rsp_err=0 after uart_cmd_rdy returns.
REQ-035 Read: req 0 cmd=16'h8055, UART returns 8'hA5 -> rsp_vld[0], rsp_data=8'hA5, rsp_err=0.
REQ-036 Round-robin: all four req_vld held high, writes -> grant order 0,1,2,3,0; no requester granted twice before others.
REQ-037 Timeout: TIMEOUT_CYC=100, read with no uart_read_rdy -> rsp_vld at 100 cycles in WAIT_RSP, rsp_data=8'hFF, rsp_err=1, then IDLE.
REQ-038 Reset asserted in WAIT_RSP -> all outputs 0 immediately, no rsp_vld; next request to req 0 served normally.
